// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the upstream bus block (master) and the
// register slave. The instance is named s0_axi at the slave port.
interface axil_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: REG0-REG3 (RW), WCOUNT (RO), ID (RO).
// Define AXIL_SLVERR_EN to answer SLVERR for unmapped accesses and RO writes.
module axil_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                  s0_axi_aclk,
  input  logic                  s0_axi_aresetn,
  axil_reg_slave_if.slave       s0_axi,
  output logic [DATA_WIDTH-1:0] ctrl_out
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  bus_en;
  logic                  awready, wready, bvalid, arready, rvalid;
  logic                  aw_hs, w_hs, b_hs, ar_hs;
  logic [IDX_W-1:0]      aw_idx_q, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data, rd_mux, rdata_q, wcount;
  logic [STRB_W-1:0]     wstrb_q, wr_strb;
  logic [1:0]            bresp_q, rresp_q;
  logic                  wr_commit, wr_err, rd_err;
  logic [DATA_WIDTH-1:0] regs [4];
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s0_axi.awaddr[1:0], s0_axi.araddr[1:0]};

  // Holds all ready outputs low until the first clock edge after reset release.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) bus_en <= 1'b0;
    else                 bus_en <= 1'b1;
  end

  assign aw_hs = s0_axi.awvalid & awready;
  assign w_hs  = s0_axi.wvalid  & wready;
  assign b_hs  = bvalid & s0_axi.bready;
  assign ar_hs = s0_axi.arvalid & arready;

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) w_state <= W_IDLE;
    else                 w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_ADDR;
        else if (w_hs)     w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)  w_next = W_RESP;
      W_HAVE_DATA: if (aw_hs) w_next = W_RESP;
      W_RESP:      if (b_hs)  w_next = W_IDLE;
      default:     w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE:      begin awready = bus_en; wready = bus_en; end
      W_HAVE_ADDR: wready  = bus_en;
      W_HAVE_DATA: awready = bus_en;
      W_RESP:      bvalid  = 1'b1;
      default:     ;
    endcase
  end

  // A channel that handshakes in the committing cycle bypasses its capture register.
  assign wr_commit = (w_state != W_RESP) && (w_next == W_RESP);
  assign wr_idx    = aw_hs ? s0_axi.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data   = w_hs  ? s0_axi.wdata : wdata_q;
  assign wr_strb   = w_hs  ? s0_axi.wstrb : wstrb_q;

`ifdef AXIL_SLVERR_EN
  assign wr_err = (wr_idx >= IDX_W'(4));
  assign rd_err = (rd_idx >= IDX_W'(6));
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
      wcount   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s0_axi.awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= s0_axi.wdata;
        wstrb_q <= s0_axi.wstrb;
      end
      if (wr_commit) begin
        bresp_q <= wr_err ? 2'b10 : 2'b00;
        if (wr_idx < IDX_W'(4)) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) regs[wr_idx[1:0]][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
      if (b_hs) wcount <= wcount + 1'b1;
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) r_state <= R_IDLE;
    else                 r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s0_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  arready = bus_en;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read data is sampled from the current register values, so a write
  // landing on the same edge is not visible to this read.
  assign rd_idx = s0_axi.araddr[ADDR_WIDTH-1:2];

  always_comb begin
    rd_mux = '0;
    if (rd_idx < IDX_W'(4))       rd_mux = regs[rd_idx[1:0]];
    else if (rd_idx == IDX_W'(4)) rd_mux = wcount;
    else if (rd_idx == IDX_W'(5)) rd_mux = ID_VALUE;
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= rd_mux;
      rresp_q <= rd_err ? 2'b10 : 2'b00;
    end
  end

  assign s0_axi.awready = awready;
  assign s0_axi.wready  = wready;
  assign s0_axi.bvalid  = bvalid;
  assign s0_axi.bresp   = bresp_q;
  assign s0_axi.arready = arready;
  assign s0_axi.rvalid  = rvalid;
  assign s0_axi.rdata   = rdata_q;
  assign s0_axi.rresp   = rresp_q;
  assign ctrl_out       = regs[0];

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard testbench for axil_reg_slave; honours AXIL_SLVERR_EN for the
// expected error responses.
module tb_axil_reg_slave;

  localparam int          DW = 32;
  localparam int          AW = 8;
  localparam logic [31:0] ID = 32'hA5A5_0001;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0]  ERR = 2'b10;
`else
  localparam logic [1:0]  ERR = 2'b00;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ctrl_out;

  int checks  = 0;
  int errors  = 0;
  int b_count = 0;

  logic [1:0]  b_q[$];
  rd_exp_t     r_q[$];
  logic [31:0] exp_regs[4];
  logic [31:0] exp_wcount;

  always #5 clk = ~clk;

  axil_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_VALUE(ID)) dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .s0_axi         (bus),
    .ctrl_out       (ctrl_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_wresp(input logic [7:0] addr);
    return (addr[7:2] >= 6'd4) ? ERR : 2'b00;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] addr);
    return (addr[7:2] >= 6'd6) ? ERR : 2'b00;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] addr);
    logic [5:0] idx = addr[7:2];
    if (idx < 6'd4)  return exp_regs[idx[1:0]];
    if (idx == 6'd4) return exp_wcount;
    if (idx == 6'd5) return ID;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
    exp_wcount = 32'h0;
  endtask

  // Monitor pops the scoreboard on every B and R handshake.
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus.bvalid && bus.bready) begin
      b_count++;
      if (b_q.size() == 0) checkOutput("b_unexpected", 32'd1, 32'd0);
      else                 checkOutput("bresp", 32'(bus.bresp), 32'(b_q.pop_front()));
    end
    if (bus.rvalid && bus.rready) begin
      if (r_q.size() == 0) checkOutput("r_unexpected", 32'd1, 32'd0);
      else begin
        e = r_q.pop_front();
        checkOutput("rdata", bus.rdata, e.data);
        checkOutput("rresp", 32'(bus.rresp), 32'(e.resp));
      end
    end
  end

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic applyWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] resp = exp_wresp(addr);
    bit         done;
    b_q.push_back(resp);
    if (addr[7:2] < 6'd4)
      for (int k = 0; k < 4; k++)
        if (strb[k]) exp_regs[addr[3:2]][8*k +: 8] = data[8*k +: 8];
    fork
      begin
        bit aw_done = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        bus.awaddr = addr; bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !aw_done; i++) begin
          @(negedge clk); aw_done = bus.awready; @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        if (!aw_done) checkOutput("aw_timeout", 32'd0, 32'd1);
      end
      begin
        bit w_done = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !w_done; i++) begin
          @(negedge clk); w_done = bus.wready; @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        if (!w_done) checkOutput("w_timeout", 32'd0, 32'd1);
      end
    join
    checkOutput("bvalid_latency", 32'(bus.bvalid), 32'd1);
    repeat (b_dly) begin
      @(negedge clk);
      checkOutput("b_hold_valid", 32'(bus.bvalid), 32'd1);
      checkOutput("b_hold_resp", 32'(bus.bresp), 32'(resp));
      checkOutput("b_hold_awready", 32'(bus.awready), 32'd0);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = bus.bvalid; @(posedge clk); #1;
    end
    bus.bready = 1'b0;
    if (!done) checkOutput("b_timeout", 32'd0, 32'd1);
    exp_wcount = exp_wcount + 32'd1;
  endtask

  task automatic applyRead(input logic [7:0] addr, input int r_dly);
    rd_exp_t e;
    bit      done = 0;
    e.data = exp_read(addr);
    e.resp = exp_rresp(addr);
    r_q.push_back(e);
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = bus.arready; @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    if (!done) checkOutput("ar_timeout", 32'd0, 32'd1);
    checkOutput("rvalid_latency", 32'(bus.rvalid), 32'd1);
    repeat (r_dly) begin @(posedge clk); #1; end
    bus.rready = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = bus.rvalid; @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    if (!done) checkOutput("r_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int b_start;
    bit done;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();

    #2;
    checkOutput("rst_awready", 32'(bus.awready), 32'd0);
    checkOutput("rst_wready", 32'(bus.wready), 32'd0);
    checkOutput("rst_arready", 32'(bus.arready), 32'd0);
    checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
    checkOutput("rst_ctrl_out", ctrl_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(bus.awready), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_edge", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

    // AW first, W three cycles later, low halfword strobes only.
    b_start = b_count;
    applyWrite(8'h00, 32'hDEAD_BEEF, 4'b0011, 0, 3, 0);
    checkOutput("reg0_partial", ctrl_out, 32'h0000_BEEF);
    checkOutput("one_b_handshake", 32'(b_count - b_start), 32'd1);

    applyWrite(8'h04, 32'h1234_5678, 4'b1111, 0, 0, 0);
    applyRead(8'h04, 0);
    applyWrite(8'h0B, 32'hCAFE_F00D, 4'b1100, 2, 0, 1);
    applyRead(8'h08, 2);
    applyRead(8'h14, 0);
    applyRead(8'h18, 1);
    applyWrite(8'h14, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
    applyWrite(8'h20, 32'h5555_5555, 4'b1111, 1, 0, 0);
    applyWrite(8'h10, 32'h0000_0000, 4'b1111, 0, 1, 0);
    applyRead(8'h14, 0);
    applyRead(8'h10, 0);

    for (int n = 0; n < 8; n++) begin
      applyWrite(8'($urandom_range(0, 7) * 4), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int a = 0; a < 8; a++) applyRead(8'(a * 4), a % 2);
    checkOutput("ctrl_out_tracks_reg0", ctrl_out, exp_regs[0]);

    // Reset while parked in W_HAVE_ADDR must abandon the write silently.
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = bus.awready; @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    if (!done) checkOutput("aw_timeout", 32'd0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    checkOutput("mid_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    checkOutput("mid_rst_ctrl_out", ctrl_out, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_start = b_count;
    bus.bready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.bready = 1'b0;
    checkOutput("no_b_after_reset", 32'(b_count - b_start), 32'd0);
    for (int a = 0; a < 5; a++) applyRead(8'(a * 4), 0);

    // bready withheld for five cycles on the first write after reset.
    applyWrite(8'h0C, 32'h1122_3344, 4'b1111, 0, 0, 5);
    checkOutput("wcount_model_one", exp_wcount, 32'd1);
    applyRead(8'h10, 0);
    applyRead(8'h0C, 0);

    force dut.wcount = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.wcount;
    exp_wcount = 32'hFFFF_FFFF;
    applyRead(8'h10, 0);
    applyWrite(8'h04, 32'h0BAD_F00D, 4'b0101, 0, 0, 0);
    applyRead(8'h10, 0);
    applyRead(8'h04, 0);

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("b_queue_drained", 32'(b_q.size()), 32'd0);
    checkOutput("r_queue_drained", 32'(r_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REG-free header note: parameters first, then ports; `s0_` prefix marks the AXI4-Lite slave port fed by the upstream bus block.
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning byte address width.
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5A5_0001, meaning constant returned by the ID register.
REQ-004 SHALL have port s0_axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port s0_axi_aresetn, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports s0_axi_awaddr (input, ADDR_WIDTH), s0_axi_awvalid (input, 1) and s0_axi_awready (output, 1) for the write-address channel.
REQ-007 SHALL have ports s0_axi_wdata (input, DATA_WIDTH), s0_axi_wstrb (input, DATA_WIDTH/8), s0_axi_wvalid (input, 1) and s0_axi_wready (output, 1) for the write-data channel.
REQ-008 SHALL have ports s0_axi_bresp (output, 2), s0_axi_bvalid (output, 1) and s0_axi_bready (input, 1) for the write-response channel.
REQ-009 SHALL have ports s0_axi_araddr (input, ADDR_WIDTH), s0_axi_arvalid (input, 1) and s0_axi_arready (output, 1) for the read-address channel.
REQ-010 SHALL have ports s0_axi_rdata (output, DATA_WIDTH), s0_axi_rresp (output, 2), s0_axi_rvalid (output, 1) and s0_axi_rready (input, 1) for the read-data channel.
REQ-011 SHALL have port ctrl_out, output, DATA_WIDTH, a continuous copy of REG0.

Function
REQ-012 SHALL decode index = addr[ADDR_WIDTH-1:2], ignoring addr[1:0]: indices 0-3 are RW REG0-REG3, index 4 is RO WCOUNT, index 5 is RO ID, and indices 6 and above are unmapped.
REQ-013 SHALL implement the write FSM states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
REQ-014 SHALL drive awready=1 in W_IDLE and W_HAVE_DATA, and wready=1 in W_IDLE and W_HAVE_ADDR; both are 0 in W_RESP.
REQ-015 SHALL make the following write FSM transitions:
- W_IDLE, AW and W handshakes in the same cycle -> W_RESP.
- W_IDLE, AW handshake only -> W_HAVE_ADDR.
- W_IDLE, W handshake only -> W_HAVE_DATA.
- W_HAVE_ADDR or W_HAVE_DATA, completion of the missing handshake -> W_RESP.
REQ-016 SHALL update the target register on the edge entering W_RESP, byte lane k being written only when wstrb[k]=1.
REQ-017 SHALL ignore writes to RO or unmapped indices, leaving all register contents unchanged.
REQ-018 SHALL assert bvalid throughout W_RESP, the first cycle after both handshakes, and hold it and bresp stable until bready=1, then return to W_IDLE on that edge.
REQ-019 SHALL increment WCOUNT by 1 on each B handshake for any address, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 SHALL implement the read FSM states R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1).
REQ-021 SHALL, on an AR handshake, register rdata and rresp and enter R_DATA, so rvalid rises one cycle after the handshake.
REQ-022 SHALL hold rdata, rresp and rvalid stable until rready=1, then return to R_IDLE on that edge.
REQ-023 SHALL return 0 in rdata for unmapped reads.
REQ-024 SHALL run the read and write FSMs independently.
REQ-025 SHALL, when a read samples a register on the same edge that a write updates it, return the pre-write value.

Reset
REQ-026 SHALL, while s0_axi_aresetn=0, immediately force: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, REG0-REG3=0, WCOUNT=0, and both FSMs to their IDLE states.
REQ-027 SHALL abandon any partially completed transaction on reset with no register update and no response.
REQ-028 SHALL assert awready, wready and arready at the first clock edge after reset deasserts.

Configuration
REQ-029 SHALL, when macro AXIL_SLVERR_EN is defined, return bresp/rresp=2'b10 (SLVERR) for unmapped accesses and for writes to RO indices.
REQ-030 SHALL, when AXIL_SLVERR_EN is undefined, return 2'b00 (OKAY) for all accesses, with function otherwise identical.

Verification
REQ-031 SHALL cover: write 0x04 with wdata 0x1234_5678 and wstrb 4'b1111, AW and W in the same cycle -> bvalid next cycle with bresp 00; then read 0x04 -> rdata 0x1234_5678, rvalid one cycle after AR.
REQ-032 SHALL cover: AW 0x00 at cycle 0 and W 0xDEAD_BEEF with wstrb 4'b0011 at cycle 3, starting from REG0=0 -> REG0=0x0000_BEEF, ctrl_out=0x0000_BEEF, and exactly one B handshake.
REQ-033 SHALL cover: read 0x14 -> rdata ID_VALUE; read 0x18 -> rdata 0, with rresp 10 when AXIL_SLVERR_EN is defined and 00 otherwise.
REQ-034 SHALL cover: bready held low for 5 cycles -> bvalid and bresp stable and awready=0 throughout; WCOUNT=1 after the handshake.
REQ-035 SHALL cover: WCOUNT forced to 0xFFFF_FFFF, then one write -> read 0x10 returns 0.
REQ-036 SHALL cover: aresetn pulsed low while in W_HAVE_ADDR -> all valids 0 immediately, REG contents 0, and no B response issued.
